// File: rtl/systolic_pkg.sv
// systolic_pkg: shared feeder state type, default dimensions and feed timing helpers.
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, FEED, DONE} feeder_state_e;
  localparam int DEF_N = 4;
  localparam int DEF_DW = 8;
  function automatic int feed_cycles(input int n);
    return 3 * n;
  endfunction
  function automatic int sample_cycle(input int n);
    return 3 * n - 1;
  endfunction
endpackage

// File: rtl/skew_lane_sel.sv
// skew_lane_sel: picks element (t - idx) of a buffer vector, zero outside 0..N-1.
module skew_lane_sel #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0] t_i,
  input  logic [CNT_W-1:0] idx_i,
  input  logic [N*DW-1:0]  vec_i,
  output logic [DW-1:0]    elem_o
);
  logic signed [CNT_W:0] d;
  always_comb begin
    d = $signed({1'b0, t_i}) - $signed({1'b0, idx_i});
    elem_o = '0;
    for (int k = 0; k < N; k++)
      if (int'(d) == k) elem_o = vec_i[k*DW +: DW];
  end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers A/B and drives skewed, zero-padded lanes plus start/sample into an NxN PE grid.
// FEEDER_DOUBLE_BUF_EN: ping-pong A/B banks swapped on each accepted start; writes accepted in every state.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DW    = DEF_DW,
  parameter int CNT_W = $clog2(feed_cycles(N) + 1),
  parameter int AW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            wr_en_i,
  input  logic            wr_sel_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [N*DW-1:0] wr_data_i,
  output logic            wr_err_o,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pe_start_o,
  output logic [N*DW-1:0] a_row_o,
  output logic [N*DW-1:0] b_col_o,
  output logic            sample_o
);
`ifdef FEEDER_DOUBLE_BUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int IW = (NB * N > 1) ? $clog2(NB * N) : 1;
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(sample_cycle(N));

  feeder_state_e state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic [N*DW-1:0] a_q [NB*N];
  logic [N*DW-1:0] a_d [NB*N];
  logic [N*DW-1:0] b_q [NB*N];
  logic [N*DW-1:0] b_d [NB*N];
  logic [N*DW-1:0] a_vec [N];
  logic [N*DW-1:0] b_vec [N];
  logic [N*DW-1:0] a_lane, b_lane, a_row_q, b_col_q;
  logic start_acc, wr_acc, bank_d, wr_bank, wr_err_d, feed_d;
  logic wr_err_q, feed_q, done_q, sample_q;
  logic [IW-1:0] wr_idx;

  assign start_acc = start_i && state_q == IDLE;

`ifdef FEEDER_DOUBLE_BUF_EN
  logic bank_q;
  assign bank_d   = start_acc ? ~bank_q : bank_q;
  assign wr_bank  = ~bank_q;
  assign wr_acc   = wr_en_i;
  assign wr_err_d = 1'b0;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) bank_q <= 1'b0;
    else bank_q <= bank_d;
`else
  assign bank_d   = 1'b0;
  assign wr_bank  = 1'b0;
  assign wr_acc   = wr_en_i && state_q == IDLE;
  assign wr_err_d = wr_en_i && state_q != IDLE;
`endif

  assign wr_idx = IW'(int'(wr_bank) * N + int'(wr_addr_i));

  // Lanes read the post-write buffer so a write coinciding with start feeds new data
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (wr_acc && !wr_sel_i) a_d[wr_idx] = wr_data_i;
    if (wr_acc && wr_sel_i) b_d[wr_idx] = wr_data_i;
  end

  always_comb
    for (int i = 0; i < N; i++) begin
      a_vec[i] = a_d[IW'(int'(bank_d) * N + i)];
      b_vec[i] = '0;
      for (int k = 0; k < N; k++)
        b_vec[i][k*DW +: DW] = b_d[IW'(int'(bank_d) * N + k)][i*DW +: DW];
    end

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_lane_sel #(.N(N), .DW(DW), .CNT_W(CNT_W)) u_a (
      .t_i(t_d), .idx_i(CNT_W'(i)), .vec_i(a_vec[i]), .elem_o(a_lane[i*DW +: DW])
    );
    skew_lane_sel #(.N(N), .DW(DW), .CNT_W(CNT_W)) u_b (
      .t_i(t_d), .idx_i(CNT_W'(i)), .vec_i(b_vec[i]), .elem_o(b_lane[i*DW +: DW])
    );
  end

  always_comb begin
    state_d = state_q;
    t_d = t_q;
    case (state_q)
      IDLE: if (start_acc) begin
        state_d = FEED;
        t_d = '0;
      end
      FEED: if (t_q == T_LAST) state_d = DONE;
            else t_d = t_q + 1'b1;
      default: begin
        state_d = IDLE;
        t_d = '0;
      end
    endcase
  end

  assign feed_d = state_d == FEED;

  // Outputs are registered from next state so cycle t of FEED shows lanes for t
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      state_q  <= IDLE;
      t_q      <= '0;
      a_q      <= '{default: '0};
      b_q      <= '{default: '0};
      wr_err_q <= 1'b0;
      feed_q   <= 1'b0;
      done_q   <= 1'b0;
      sample_q <= 1'b0;
      a_row_q  <= '0;
      b_col_q  <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wr_err_q <= wr_err_d;
      feed_q   <= feed_d;
      done_q   <= state_d == DONE;
      sample_q <= feed_d && t_d == T_LAST;
      a_row_q  <= feed_d ? a_lane : '0;
      b_col_q  <= feed_d ? b_lane : '0;
    end

  assign wr_err_o   = wr_err_q;
  assign busy_o     = feed_q;
  assign pe_start_o = feed_q;
  assign done_o     = done_q;
  assign sample_o   = sample_q;
  assign a_row_o    = a_row_q;
  assign b_col_o    = b_col_q;
endmodule
